// File: rtl/jtag_tap_driver.sv
// Command-driven JTAG master: bit-bangs tck/tms/tdi from Run-Test/Idle and back, and captures tdo.
// Optional macro JTAG_TAP_DRIVER_STATE_OUT_EN adds the tap_state output (driver's model of the TAP state).
module jtag_tap_driver #(
    parameter int CLK_DIV  = 2,
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
`ifdef JTAG_TAP_DRIVER_STATE_OUT_EN
    ,
    output logic [3:0]          tap_state
`endif
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (LEN_W > 3) ? LEN_W : 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_PRE   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_POST  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // tms value carried by a given slot of the command walk
    function automatic logic slot_tms(input state_t st, input logic [IDX_W-1:0] idx,
                                      input logic [1:0] op, input logic [IDX_W-1:0] last);
        logic r;
        case (st)
            ST_SYNC:  r = (idx < IDX_W'(3'd5));
            ST_PRE:   r = (op == OP_IR) ? (idx < IDX_W'(2'd2)) : (idx == IDX_W'(1'b0));
            ST_SHIFT: r = (op != OP_IDLE) && (idx == last);
            ST_POST:  r = (idx == IDX_W'(1'b0));
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef JTAG_TAP_DRIVER_STATE_OUT_EN
    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        logic [3:0] r;
        case (s)
            4'd0:    r = m ? 4'd0  : 4'd1;
            4'd1:    r = m ? 4'd2  : 4'd1;
            4'd2:    r = m ? 4'd9  : 4'd3;
            4'd3:    r = m ? 4'd5  : 4'd4;
            4'd4:    r = m ? 4'd5  : 4'd4;
            4'd5:    r = m ? 4'd8  : 4'd6;
            4'd6:    r = m ? 4'd7  : 4'd6;
            4'd7:    r = m ? 4'd8  : 4'd4;
            4'd8:    r = m ? 4'd2  : 4'd1;
            4'd9:    r = m ? 4'd0  : 4'd10;
            4'd10:   r = m ? 4'd12 : 4'd11;
            4'd11:   r = m ? 4'd12 : 4'd11;
            4'd12:   r = m ? 4'd15 : 4'd13;
            4'd13:   r = m ? 4'd14 : 4'd13;
            4'd14:   r = m ? 4'd15 : 4'd11;
            4'd15:   r = m ? 4'd2  : 4'd1;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    logic [3:0] tap_state_q;
    assign tap_state = tap_state_q;
`endif

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [1:0]          op_q;
    logic [LEN_W-1:0]    n_q;
    logic [MAX_BITS-1:0] sh_q;
    logic [MAX_BITS-1:0] cap_q;
    logic                synced_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [MAX_BITS-1:0] rsp_data_q;
    logic                busy_q;
    logic                tck_q;
    logic                tms_q;
    logic                tdi_q;

    logic [LEN_W-1:0]    n_in_s;
    state_t              start_state_d;
    logic                start_tms_d;
    logic [IDX_W-1:0]    last_idx_s;
    logic [IDX_W-1:0]    pre_last_s;
    state_t              adv_state_d;
    logic [IDX_W-1:0]    adv_idx_d;
    logic                adv_done_d;
    logic                adv_tms_d;
    logic                adv_tdi_d;
    logic [MAX_BITS-1:0] sh_nxt_s;

    // Effective length: shift ops clamp to 1..MAX_BITS, idle op uses the raw count
    always_comb begin
        n_in_s = cmd_len;
        if (cmd_op == OP_IR || cmd_op == OP_DR) begin
            if (cmd_len == LEN_W'(1'b0)) begin
                n_in_s = LEN_W'(1'b1);
            end else if (cmd_len > LEN_W'(MAX_BITS)) begin
                n_in_s = LEN_W'(MAX_BITS);
            end else begin
                n_in_s = cmd_len;
            end
        end else begin
            n_in_s = cmd_len;
        end
    end

    // First slot of a freshly accepted command
    always_comb begin
        start_state_d = ST_PRE;
        if (!synced_q || cmd_op == OP_RESET) begin
            start_state_d = ST_SYNC;
        end else if (cmd_op == OP_IDLE) begin
            start_state_d = (cmd_len == LEN_W'(1'b0)) ? ST_RESP : ST_SHIFT;
        end else begin
            start_state_d = ST_PRE;
        end
        start_tms_d = slot_tms(start_state_d, IDX_W'(1'b0), cmd_op, IDX_W'(n_in_s) - IDX_W'(1'b1));
    end

    // Slot that follows the current one once its high phase ends
    always_comb begin
        last_idx_s  = IDX_W'(n_q) - IDX_W'(1'b1);
        pre_last_s  = (op_q == OP_IR) ? IDX_W'(2'd3) : IDX_W'(2'd2);
        sh_nxt_s    = sh_q >> 1;
        adv_state_d = state_q;
        adv_idx_d   = idx_q + IDX_W'(1'b1);
        adv_done_d  = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (idx_q == IDX_W'(3'd5)) begin
                    adv_idx_d = IDX_W'(1'b0);
                    if (op_q == OP_RESET || (op_q == OP_IDLE && n_q == LEN_W'(1'b0))) begin
                        adv_done_d = 1'b1;
                    end else if (op_q == OP_IDLE) begin
                        adv_state_d = ST_SHIFT;
                    end else begin
                        adv_state_d = ST_PRE;
                    end
                end else begin
                    adv_state_d = ST_SYNC;
                end
            end
            ST_PRE: begin
                if (idx_q == pre_last_s) begin
                    adv_state_d = ST_SHIFT;
                    adv_idx_d   = IDX_W'(1'b0);
                end else begin
                    adv_state_d = ST_PRE;
                end
            end
            ST_SHIFT: begin
                if (idx_q == last_idx_s) begin
                    adv_idx_d = IDX_W'(1'b0);
                    if (op_q == OP_IDLE) begin
                        adv_done_d = 1'b1;
                    end else begin
                        adv_state_d = ST_POST;
                    end
                end else begin
                    adv_state_d = ST_SHIFT;
                end
            end
            ST_POST: begin
                if (idx_q != IDX_W'(1'b0)) begin
                    adv_done_d = 1'b1;
                end else begin
                    adv_state_d = ST_POST;
                end
            end
            default: adv_done_d = 1'b1;
        endcase
        adv_tms_d = slot_tms(adv_state_d, adv_idx_d, op_q, last_idx_s);
        if (adv_state_d == ST_SHIFT && op_q != OP_IDLE && !adv_done_d) begin
            adv_tdi_d = (state_q == ST_SHIFT) ? sh_nxt_s[0] : sh_q[0];
        end else begin
            adv_tdi_d = 1'b0;
        end
    end

    // Command FSM, bit-slot timing and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            op_q        <= 2'd0;
            n_q         <= '0;
            sh_q        <= '0;
            cap_q       <= '0;
            synced_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
`ifdef JTAG_TAP_DRIVER_STATE_OUT_EN
            tap_state_q <= 4'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        n_q         <= n_in_s;
                        sh_q        <= cmd_data;
                        cap_q       <= '0;
                        rsp_data_q  <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        idx_q       <= '0;
                        tck_q       <= 1'b0;
                        tms_q       <= start_tms_d;
                        tdi_q       <= 1'b0;
                        state_q     <= start_state_d;
                        rsp_valid_q <= (start_state_d == ST_RESP);
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_SYNC, ST_PRE, ST_SHIFT, ST_POST: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1'b1);
                    end else begin
                        cnt_q <= '0;
                        if (!tck_q) begin
                            tck_q <= 1'b1;
                            if (state_q == ST_SHIFT && op_q != OP_IDLE) begin
                                cap_q <= cap_q | (MAX_BITS'(tdo) << idx_q);
                            end
`ifdef JTAG_TAP_DRIVER_STATE_OUT_EN
                            tap_state_q <= tap_next(tap_state_q, tms_q);
`endif
                        end else begin
                            tck_q <= 1'b0;
                            if (state_q == ST_SYNC && idx_q == IDX_W'(3'd5)) begin
                                synced_q <= 1'b1;
                            end
                            if (adv_done_d) begin
                                state_q     <= ST_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= cap_q;
                                tms_q       <= 1'b0;
                                tdi_q       <= 1'b0;
                            end else begin
                                state_q <= adv_state_d;
                                idx_q   <= adv_idx_d;
                                tms_q   <= adv_tms_d;
                                tdi_q   <= adv_tdi_d;
                                if (state_q == ST_SHIFT && adv_state_d == ST_SHIFT) begin
                                    sh_q <= sh_nxt_s;
                                end
                            end
                        end
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: an IEEE-style TAP model answers on tdo, expected walks come from the command rules.
module tb_jtag_tap_driver;

    localparam int CLK_DIV  = 2;
    localparam int MAX_BITS = 32;
    localparam int LEN_W    = $clog2(MAX_BITS + 1);

    logic                clk = 1'b0;
    logic                reset_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [LEN_W-1:0]    cmd_len;
    logic [MAX_BITS-1:0] cmd_data;
    logic                rsp_valid;
    logic [MAX_BITS-1:0] rsp_data;
    logic                busy;
    logic                tck;
    logic                tms;
    logic                tdi;
    logic                tdo = 1'b0;
`ifdef JTAG_TAP_DRIVER_STATE_OUT_EN
    logic [3:0]          tap_state;
`endif

    jtag_tap_driver #(.CLK_DIV(CLK_DIV), .MAX_BITS(MAX_BITS)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
`ifdef JTAG_TAP_DRIVER_STATE_OUT_EN
        , .tap_state(tap_state)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // TAP transition table indexed by current state, one table per tms value
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          ts = 0;
    int          scnt = 0;
    logic [63:0] shin = '0;
    logic [63:0] tdo_pat = '0;
    bit          tms_seen[$];
    bit          tdi_seen[$];
    int          rises = 0;
    int          rsp_cnt = 0;
    int          phase_bad = 0;
    int          ph_len = 0;
    bit          low_ok = 1'b0;
    logic        prev_tck = 1'b0;
    bit          model_synced = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line monitor and TAP model, sampled on the falling clk edge
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_cnt++;
        if (tck !== prev_tck) begin
            if ((prev_tck === 1'b1 || low_ok) && ph_len != CLK_DIV) phase_bad++;
            if (tck === 1'b1) begin
                rises++;
                tms_seen.push_back(tms);
                tdi_seen.push_back(tdi);
                if (ts == 4 || ts == 11) begin
                    if (scnt < 64) shin[scnt] = tdi;
                    scnt++;
                end
                if (ts == 3 || ts == 10) begin
                    scnt = 0;
                    shin = '0;
                end
                ts = tms ? nxt1[ts] : nxt0[ts];
            end else begin
                low_ok = 1'b1;
            end
            ph_len = 1;
        end else begin
            ph_len++;
        end
        prev_tck = tck;
        if (tck === 1'b0) tdo = ((ts == 4 || ts == 11) && scnt < 64) ? tdo_pat[scnt] : 1'b0;
    end

    task automatic issue(input logic [1:0] op, input int len, input logic [31:0] data,
                         input logic [63:0] pat);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", cmd_ready, 1'b1);
        tms_seen.delete();
        tdi_seen.delete();
        rises = 0; rsp_cnt = 0; phase_bad = 0; low_ok = 1'b0;
        tdo_pat  = pat;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        cmd_len   = LEN_W'($urandom_range(0, 63));
        chk("busy_after_accept", busy, 1'b1);
        chk("ready_after_accept", cmd_ready, 1'b0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                           input logic [63:0] pat);
        bit          exp_tms[$];
        int          n, cyc, off;
        logic [63:0] mask, exp_rsp, obs_tms, exp_tms_v;
        logic        idle_tdi;
        n = (op == 2'd0) ? 0 : (op == 2'd3) ? len : (len == 0 ? 1 : (len > MAX_BITS ? MAX_BITS : len));
        if (!model_synced || op == 2'd0) begin
            for (int i = 0; i < 6; i++) exp_tms.push_back(i < 5);
        end
        off = exp_tms.size();
        if (op == 2'd1) begin
            exp_tms.push_back(1'b1); exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0); exp_tms.push_back(1'b0);
        end
        if (op == 2'd2) begin
            exp_tms.push_back(1'b1); exp_tms.push_back(1'b0); exp_tms.push_back(1'b0);
        end
        if (op == 2'd1 || op == 2'd2) begin
            for (int i = 0; i < n; i++) exp_tms.push_back(i == n - 1);
            exp_tms.push_back(1'b1); exp_tms.push_back(1'b0);
        end
        if (op == 2'd3) begin
            for (int i = 0; i < n; i++) exp_tms.push_back(1'b0);
        end
        mask    = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        exp_rsp = (op == 2'd1 || op == 2'd2) ? (pat & mask) : 64'd0;

        issue(op, len, data, pat);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rsp_seen", rsp_valid, 1'b1);
        chk("rsp_latency", cyc, 2 * CLK_DIV * exp_tms.size());
        chk("rsp_data", rsp_data, exp_rsp);
        chk("busy_at_rsp", busy, 1'b1);
        chk("ready_at_rsp", cmd_ready, 1'b0);
        chk("tck_count", rises, exp_tms.size());
        obs_tms = '0;
        exp_tms_v = '0;
        for (int i = 0; i < 64 && i < tms_seen.size(); i++) obs_tms[i] = tms_seen[i];
        for (int i = 0; i < 64 && i < exp_tms.size(); i++) exp_tms_v[i] = exp_tms[i];
        chk("tms_walk", obs_tms, exp_tms_v);
        if (op == 2'd1 || op == 2'd2) chk("tdi_shifted", shin, {32'd0, data} & mask);
        if (op == 2'd3) begin
            idle_tdi = 1'b0;
            for (int i = off; i < tdi_seen.size(); i++) idle_tdi = idle_tdi | tdi_seen[i];
            chk("idle_tdi", idle_tdi, 1'b0);
        end
        @(negedge clk);
        chk("rsp_pulse_once", rsp_cnt, 1);
        chk("rsp_valid_low", rsp_valid, 1'b0);
        chk("ready_after_rsp", cmd_ready, 1'b1);
        chk("busy_after_rsp", busy, 1'b0);
        chk("lines_idle", {tck, tms, tdi}, 3'b000);
        chk("tap_in_rti", ts, 1);
        chk("half_periods", phase_bad, 0);
        chk("rsp_data_hold", rsp_data, exp_rsp);
`ifdef JTAG_TAP_DRIVER_STATE_OUT_EN
        chk("tap_state_out", tap_state, 4'd1);
`endif
        model_synced = 1'b1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_synced = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int w;
        logic [1:0] op;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_tck", tck, 1'b0);
        chk("rst_tms", tms, 1'b1);
        chk("rst_tdi", tdi, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_busy", busy, 1'b0);
`ifdef JTAG_TAP_DRIVER_STATE_OUT_EN
        chk("rst_tap_state", tap_state, 4'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1'b1);

        run_cmd(2'd0, 5, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_cmd(2'd2, 8, 32'h0000_00A5, 64'h3C);
        run_cmd(2'd3, 3, 32'hFFFF_FFFF, 64'h0);
        run_cmd(2'd3, 0, 32'h1234_5678, 64'h0);
        run_cmd(2'd2, 0, 32'h0000_0001, 64'h1);
        run_cmd(2'd2, 40, 32'hDEAD_BEEF, 64'hFFFF_0123_4567_89AB);

        pulse_reset();
        run_cmd(2'd1, 4, 32'h0000_0005, 64'hA);

        // Abort a DR shift during bit 3: pre takes 3 tck, bits 0..2 take 3 more
        issue(2'd2, 8, 32'h0000_00C3, 64'h55);
        w = 0;
        while (!(rises == 6 && tck === 1'b0) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reach_bit3", rises, 6);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_tck", tck, 1'b0);
        chk("abort_tms", tms, 1'b1);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", cmd_ready, 1'b0);
        chk("abort_rsp_data", rsp_data, 64'd0);
        reset_n = 1'b1;
        model_synced = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", rsp_cnt, 0);
        run_cmd(2'd2, 8, 32'h0000_0096, 64'h69);

        for (int k = 0; k < 24; k++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd3) run_cmd(op, $urandom_range(0, 12), $urandom, {$urandom, $urandom});
            else run_cmd(op, $urandom_range(0, 40), $urandom, {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
